// File: rtl/ram_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_dump_ctrl
// Description : Fill/dump controller around an inferred single-port RAM.
//               Streams dumped words MSB byte first to a byte UART.
//               Optional macro DUMP_CHECKSUM_EN appends an 8-bit sum byte.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_dump_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_seed,
    input  logic              dump_start,
    input  logic [ADDR_W-1:0] dump_addr,
    input  logic [ADDR_W-1:0] dump_len,
    input  logic              tx_done,
    output logic              send_en,
    output logic [7:0]        data_byte,
    output logic              busy,
    output logic              done
);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NBYTES = DATA_W / 8;
    localparam int BI_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CNT_W  = ADDR_W + 1;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FILL      = 4'd1,
        RD_REQ    = 4'd2,
        RD_WAIT   = 4'd3,
        SEND      = 4'd4,
        WAIT_TX   = 4'd5,
        NEXT      = 4'd6,
        FIN       = 4'd7
`ifdef DUMP_CHECKSUM_EN
        ,
        CSUM_SEND = 4'd8,
        CSUM_WAIT = 4'd9
`endif
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] seed;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic [BI_W-1:0]   byte_idx;
    logic [DATA_W-1:0] mem [DEPTH];
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign wr_en   = (state == FILL);
    assign wr_data = seed + DATA_W'(addr);

    // Single shared address port; read data is valid one cycle after RD_REQ.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
        rd_data <= mem[addr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        send_en   = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;
        data_byte = shreg[DATA_W-1 -: 8];
        case (state)
            IDLE: begin
                if (fill_start) begin
                    state_nx = FILL;
                end else if (dump_start) begin
                    state_nx = RD_REQ;
                end
            end
            FILL: begin
                if (&addr) begin
                    state_nx = FIN;
                end
            end
            RD_REQ:  state_nx = RD_WAIT;
            RD_WAIT: state_nx = SEND;
            SEND: begin
                send_en  = 1'b1;
                state_nx = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    state_nx = (byte_idx != '0) ? SEND : NEXT;
                end
            end
            NEXT: begin
                if (cnt == CNT_W'(1)) begin
`ifdef DUMP_CHECKSUM_EN
                    state_nx = CSUM_SEND;
`else
                    state_nx = FIN;
`endif
                end else begin
                    state_nx = RD_REQ;
                end
            end
`ifdef DUMP_CHECKSUM_EN
            CSUM_SEND: begin
                send_en  = 1'b1;
                state_nx = CSUM_WAIT;
            end
            CSUM_WAIT: begin
                if (tx_done) begin
                    state_nx = FIN;
                end
            end
`endif
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr     <= '0;
            cnt      <= '0;
            seed     <= '0;
            shreg    <= '0;
            byte_idx <= '0;
`ifdef DUMP_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (fill_start) begin
                        addr <= '0;
                        seed <= fill_seed;
                    end else if (dump_start) begin
                        addr <= dump_addr;
                        cnt  <= (dump_len == '0) ? CNT_W'(DEPTH) : {1'b0, dump_len};
`ifdef DUMP_CHECKSUM_EN
                        csum <= '0;
`endif
                    end
                end
                FILL: addr <= addr + 1'b1;
                RD_WAIT: begin
                    shreg    <= rd_data;
                    byte_idx <= BI_W'(NBYTES - 1);
                end
`ifdef DUMP_CHECKSUM_EN
                SEND: csum <= csum + shreg[DATA_W-1 -: 8];
`endif
                WAIT_TX: begin
                    if (tx_done && (byte_idx != '0)) begin
                        shreg    <= shreg << 8;
                        byte_idx <= byte_idx - 1'b1;
                    end
                end
                NEXT: begin
                    cnt  <= cnt - 1'b1;
                    addr <= addr + 1'b1;
`ifdef DUMP_CHECKSUM_EN
                    // Park the finished sum in the output byte lane.
                    if (cnt == CNT_W'(1)) begin
                        shreg <= DATA_W'(csum) << (DATA_W - 8);
                    end
`endif
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire
